proc_imem_resp_drop_queue: RTL and testbench
============================================

Name: proc_imem_resp_drop_queue

Overview:
- Sits between the instruction-memory response stream and the D-stage instruction register.
- Buffers fetch responses in a small bypass queue.
- Discards responses belonging to squashed fetches when control asserts imem_respstream_drop, including responses still in flight.
- Guarantees the datapath only ever sees responses for live fetches, in order.

Parameters:
- p_num_entries, 2, queue depth in response words (>=1).
- p_msg_nbits, 32, response payload width (instruction data).
- p_max_drops, 3, maximum outstanding in-flight drops tracked; counter width = $clog2(p_max_drops+1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- drop  input  1  ctrl pulse: discard the oldest not-yet-delivered response
- enq_val  input  1  response from imem valid
- enq_rdy  output  1  block can accept response
- enq_msg  input  p_msg_nbits  response data
- deq_val  output  1  live response available to D stage
- deq_rdy  input  1  D stage accepts response
- deq_msg  output  p_msg_nbits  response data to D stage
- num_free  output  $clog2(p_num_entries+1)  free queue entries
- drop_overflow  output  1  sticky error: drop requested with counter at p_max_drops

Behaviour:
- State:
  - circular storage with head/tail pointers and count, wrapping at p_num_entries;
  - pend_drops counter;
  - drop_overflow flag.
- Reset (synchronous): count=0, head=tail=0, pend_drops=0, drop_overflow=0. Outputs after reset: deq_val=0, enq_rdy=1, num_free=p_num_entries, drop_overflow=0. Reset mid-operation discards all stored entries and pending drops.
- Candidate head ("cand"):
  - if count>0: storage[head];
  - else if enq_val and pend_drops==0: enq_msg (bypass, zero-cycle latency).
- deq_val = cand exists && pend_drops==0 && !drop.
- deq_msg = cand data; don't-care when deq_val=0.
- enq_rdy = (pend_drops>0) || (count<p_num_entries).
- Drop handling in a cycle with drop=1:
  - cand exists: cand is discarded this cycle (stored head popped, or bypassed enq consumed and not stored); pend_drops unchanged.
  - no cand: pend_drops increments.
- Draining: while pend_drops>0, each enq_val&&enq_rdy is consumed, not stored, and decrements pend_drops.
- Simultaneous drop, pend_drops>0 and enq_val: arrival discarded (-1) and new drop recorded (+1); net pend_drops unchanged.
- Invariant: pend_drops>0 implies count==0. A violation is a design bug; the bench must assert it.
- Storage write: enq fires && pend_drops==0 && not consumed via bypass (deq fire or drop) → write storage[tail], tail++.
- Storage read: deq fire or drop-of-stored-head → head++.
- Simultaneous enq-store and head-pop when full: enq_rdy is still 0 when count==p_num_entries; no same-cycle pass-through when full (avoids a rdy→rdy combinational path).
- Drop with pend_drops==p_max_drops and no cand: counter holds, drop_overflow set to 1 until reset.
- num_free = p_num_entries - count (registered-state derived, combinational).
- No combinational path from deq_rdy to enq_rdy.
- Paths from enq_val/enq_msg/drop to deq_* are combinational (bypass).

Test Plan:
- Bypass: empty queue, enq_val=1 msg=0x00000013, deq_rdy=1 → same cycle deq_val=1 deq_msg=0x00000013; count stays 0, num_free=2.
- Backpressure/fill: deq_rdy=0, enqueue 0xA, 0xB → enq_rdy=0 after second, num_free=0. Then deq_rdy=1 → deq_msg 0xA then 0xB on consecutive cycles; enq_rdy=1 once count<2.
- Drop stored head: queue holds 0xA, 0xB; drop=1 for one cycle → deq_val=0 that cycle; next cycle deq_msg=0xB; 0xA never delivered.
- In-flight drop: empty, no enq, drop pulses 2 cycles → pend_drops=2. Then enq 0x1, 0x2, 0x3 on successive cycles → 0x1 and 0x2 discarded; only 0x3 delivered (deq_val=1, msg=0x3).
- Simultaneous: pend_drops=1, drop=1 with enq_val msg=0x5 → 0x5 discarded, pend_drops stays 1. Next enq 0x6 discarded; 0x7 delivered.
- Overflow and reset: four drops with no responses (p_max_drops=3) → pend_drops=3, drop_overflow=1. Assert reset for one cycle → drop_overflow=0, pend_drops=0, deq_val=0, enq_rdy=1, num_free=2; next enq 0x9 bypassed immediately.

Source files
------------

// File: rtl/proc_imem_resp_drop_queue_if.sv
// Valid/ready response channel carrying one instruction word per beat.
interface proc_imem_resp_drop_queue_if #(
    parameter int p_msg_nbits = 32
);
    logic                   val;
    logic                   rdy;
    logic [p_msg_nbits-1:0] msg;

    modport master (output val, output msg, input  rdy);
    modport slave  (input  val, input  msg, output rdy);
endinterface

// File: rtl/proc_imem_resp_drop_queue.sv
// Imem response queue that discards squashed fetches; zero-cycle bypass when empty.
// enq stalls only when full with no pending drops; deq_rdy never reaches enq_rdy.
module proc_imem_resp_drop_queue #(
    parameter int p_num_entries = 2,
    parameter int p_msg_nbits   = 32,
    parameter int p_max_drops   = 3,
    localparam int cnt_w = $clog2(p_num_entries + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                drop,
    proc_imem_resp_drop_queue_if.slave          enq,
    proc_imem_resp_drop_queue_if.master         deq,
    output logic [cnt_w-1:0]                    num_free,
    output logic                                drop_overflow
);
    localparam int ptr_w = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int drp_w = $clog2(p_max_drops + 1);
    localparam logic [ptr_w-1:0] ptr_last  = ptr_w'(p_num_entries - 1);
    localparam logic [cnt_w-1:0] cnt_full  = cnt_w'(p_num_entries);
    localparam logic [drp_w-1:0] drops_max = drp_w'(p_max_drops);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [ptr_w-1:0]       head;
    logic [ptr_w-1:0]       tail;
    logic [cnt_w-1:0]       count;
    logic [drp_w-1:0]       pend_drops;

    logic no_pend;
    logic stored;
    logic byp_ok;
    logic cand;
    logic enq_fire;
    logic deq_fire;
    logic pop;
    logic byp_used;
    logic wr_en;
    logic drain;
    logic drop_pend;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_last) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        no_pend   = (pend_drops == '0);
        stored    = (count != '0);
        byp_ok    = !stored && enq.val && no_pend;
        cand      = stored || byp_ok;

        deq.val   = cand && no_pend && !drop;
        deq.msg   = stored ? mem[head] : enq.msg;
        // Full with nothing to drain: no pass-through, so deq_rdy stays off this path.
        enq.rdy   = !no_pend || (count < cnt_full);

        enq_fire  = enq.val && enq.rdy;
        deq_fire  = deq.val && deq.rdy;
        pop       = stored && (deq_fire || drop);
        byp_used  = byp_ok && (deq_fire || drop);
        wr_en     = enq_fire && no_pend && !byp_used;
        drain     = enq_fire && !no_pend;
        drop_pend = drop && !cand;

        num_free  = cnt_full - count;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail] <= enq.msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            pend_drops    <= '0;
            drop_overflow <= 1'b0;
        end else begin
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (wr_en) begin
                tail <= ptr_inc(tail);
            end
            count <= count + cnt_w'(wr_en) - cnt_w'(pop);

            // A drop and a drained arrival in one cycle cancel out.
            if (drop_pend && !drain) begin
                if (pend_drops == drops_max) begin
                    drop_overflow <= 1'b1;
                end else begin
                    pend_drops <= pend_drops + 1'b1;
                end
            end else if (!drop_pend && drain) begin
                pend_drops <= pend_drops - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_proc_imem_resp_drop_queue.sv
// Directed vector table plus randomized run against a queue-level reference model.
module tb_proc_imem_resp_drop_queue;
    localparam int N   = 2;
    localparam int MAX = 3;

    typedef struct {
        bit          val;
        logic [31:0] msg;
        bit          rdy;
        logic [1:0]  free;
        bit          ovf;
    } obs_t;

    typedef struct {
        bit          r;
        bit          d;
        bit          ev;
        logic [31:0] m;
        bit          dr;
        obs_t        x;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       drop;
    logic [1:0] num_free;
    logic       drop_overflow;

    proc_imem_resp_drop_queue_if #(.p_msg_nbits(32)) enq_if ();
    proc_imem_resp_drop_queue_if #(.p_msg_nbits(32)) deq_if ();

    proc_imem_resp_drop_queue #(
        .p_num_entries(N),
        .p_msg_nbits  (32),
        .p_max_drops  (MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .drop         (drop),
        .enq          (enq_if),
        .deq          (deq_if),
        .num_free     (num_free),
        .drop_overflow(drop_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq[$];
    int          mpend = 0;
    bit          movf  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".deq_val"}, 32'(a.val), 32'(e.val));
        chk({tag, ".enq_rdy"}, 32'(a.rdy), 32'(e.rdy));
        chk({tag, ".num_free"}, 32'(a.free), 32'(e.free));
        chk({tag, ".drop_overflow"}, 32'(a.ovf), 32'(e.ovf));
        if (e.val) chk({tag, ".deq_msg"}, a.msg, e.msg);
    endtask

    // Pending drops only exist while nothing is stored.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_cmp++;
            if (dut.pend_drops != '0 && dut.count != '0) begin
                n_bad++;
                $display("FAIL invariant: pend_drops=%0d count=%0d required count=0",
                         dut.pend_drops, dut.count);
            end
        end
    end

    // One clock: drive, observe mid-cycle, predict from the model, then commit the model.
    task automatic cycle(input bit r, input bit d, input bit ev, input logic [31:0] m,
                         input bit dr, output obs_t act, output obs_t exp);
        bit          has_cand;
        bit          taken;
        bit          accepted;
        bit          drained;
        int          p0;
        reset       = r;
        drop        = d;
        enq_if.val  = ev;
        enq_if.msg  = m;
        deq_if.rdy  = dr;
        @(negedge clk);
        act.val  = deq_if.val;
        act.msg  = deq_if.msg;
        act.rdy  = enq_if.rdy;
        act.free = num_free;
        act.ovf  = drop_overflow;

        has_cand = (mq.size() > 0) || (ev && mpend == 0);
        exp.val  = has_cand && mpend == 0 && !d;
        exp.msg  = (mq.size() > 0) ? mq[0] : m;
        exp.rdy  = (mpend > 0) || (mq.size() < N);
        exp.free = 2'(N - mq.size());
        exp.ovf  = movf;

        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            mpend = 0;
            movf  = 0;
        end else begin
            p0       = mpend;
            taken    = d || (exp.val && dr);
            accepted = ev && exp.rdy;
            drained  = 0;
            if (mq.size() > 0) begin
                if (taken) void'(mq.pop_front());
                if (accepted) mq.push_back(m);
            end else if (has_cand) begin
                // Head came straight from the arrival; stored only if nobody took it.
                if (!taken) mq.push_back(m);
            end else if (accepted) begin
                drained = 1;
            end
            mpend = p0 - (drained ? 1 : 0);
            if (d && !has_cand) begin
                if (p0 == MAX && !drained) movf = 1;
                else mpend = mpend + 1;
            end
        end
    endtask

    function automatic vec_t v(bit r, bit d, bit ev, logic [31:0] m, bit dr,
                               bit xv, logic [31:0] xm, bit xr, int xf, bit xo);
        vec_t t;
        t.r = r; t.d = d; t.ev = ev; t.m = m; t.dr = dr;
        t.x.val = xv; t.x.msg = xm; t.x.rdy = xr; t.x.free = 2'(xf); t.x.ovf = xo;
        return t;
    endfunction

    initial begin
        vec_t vecs[$];
        obs_t a;
        obs_t e;
        bit   r;
        bit   d;
        bit   ev;
        bit   dr;

        //        r d ev msg      dr   val msg     rdy free ovf
        vecs.push_back(v(0,0,0,32'h0 ,0,  0,32'h0 ,1,2,0)); // reset state
        vecs.push_back(v(0,0,1,32'h13,1,  1,32'h13,1,2,0)); // bypass
        vecs.push_back(v(0,0,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'hA ,0,  1,32'hA ,1,2,0)); // fill
        vecs.push_back(v(0,0,1,32'hB ,0,  1,32'hA ,1,1,0));
        vecs.push_back(v(0,0,0,32'h0 ,0,  1,32'hA ,0,0,0));
        vecs.push_back(v(0,0,0,32'h0 ,1,  1,32'hA ,0,0,0)); // drain in order
        vecs.push_back(v(0,0,0,32'h0 ,1,  1,32'hB ,1,1,0));
        vecs.push_back(v(0,0,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'hA ,0,  1,32'hA ,1,2,0)); // drop stored head
        vecs.push_back(v(0,0,1,32'hB ,0,  1,32'hA ,1,1,0));
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,0,0,0));
        vecs.push_back(v(0,0,0,32'h0 ,1,  1,32'hB ,1,1,0));
        vecs.push_back(v(0,0,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0)); // in-flight drops
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'h1 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'h2 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'h3 ,1,  1,32'h3 ,1,2,0));
        vecs.push_back(v(0,0,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0)); // drop with arrival
        vecs.push_back(v(0,1,1,32'h5 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'h6 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'h7 ,1,  1,32'h7 ,1,2,0));
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0)); // overflow
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,1,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,0,32'h0 ,1,  0,32'h0 ,1,2,1));
        vecs.push_back(v(1,0,0,32'h0 ,1,  0,32'h0 ,1,2,1)); // sync reset
        vecs.push_back(v(0,0,0,32'h0 ,1,  0,32'h0 ,1,2,0));
        vecs.push_back(v(0,0,1,32'h9 ,1,  1,32'h9 ,1,2,0));

        reset = 1'b1; drop = 1'b0;
        enq_if.val = 1'b0; enq_if.msg = '0; deq_if.rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].d, vecs[i].ev, vecs[i].m, vecs[i].dr, a, e);
            chk_obs($sformatf("vec%0d", i), a, vecs[i].x);
        end

        // Reset while two entries are stored must lose them.
        cycle(0, 0, 1, 32'hC1, 0, a, e);
        cycle(0, 0, 1, 32'hC2, 0, a, e);
        chk("midrst.full_rdy", 32'(enq_if.rdy), 32'h0);
        cycle(1, 0, 0, 32'h0, 1, a, e);
        chk("midrst.pend_drops", 32'(dut.pend_drops), 32'h0);
        cycle(0, 0, 0, 32'h0, 1, a, e);
        chk("midrst.deq_val", 32'(a.val), 32'h0);
        chk("midrst.num_free", 32'(a.free), 32'h2);
        cycle(0, 0, 1, 32'hD0, 1, a, e);
        chk("midrst.bypass_msg", a.msg, 32'hD0);

        // Three in-flight drops fill the tracker exactly.
        repeat (3) cycle(0, 1, 0, 32'h0, 1, a, e);
        chk("maxdrops.pend", 32'(dut.pend_drops), 32'h3);
        chk("maxdrops.ovf", 32'(drop_overflow), 32'h0);
        cycle(1, 0, 0, 32'h0, 1, a, e);

        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            d  = ($urandom_range(0, 5) == 0);
            ev = $urandom_range(0, 1);
            dr = ($urandom_range(0, 3) != 0);
            if (d && ev && mpend == MAX) ev = 0;
            cycle(r, d, ev, $urandom, dr, a, e);
            chk_obs($sformatf("rnd%0d", i), a, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
